// File: rtl/bcd_display_scan.sv
// Two-digit common-anode seven-segment scanner for BCD tens/ones digits.
// Shadow registers are reloaded once per frame so both digits come from the same sample.
module bcd_display_scan #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
  localparam logic          SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_INV  = (AN_ACTIVE_LOW != 0);

  typedef enum logic {SLOT_ONES, SLOT_TENS} slot_t;

  slot_t         slot;
  logic [CW-1:0] cnt;
  logic [3:0]    shadow_tens;
  logic [3:0]    shadow_ones;
  logic          primed;

  logic          tick;
  logic          capture;
  logic [3:0]    cur_digit;
  logic [6:0]    pattern;
  logic          dark;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;

  always_comb begin
    tick      = (cnt == LAST);
    capture   = !primed || (tick && slot == SLOT_TENS);
    cur_digit = (slot == SLOT_TENS) ? shadow_tens : shadow_ones;
    case (cur_digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    // Shadows are not yet valid before the first capture, so keep the display dark.
    dark = blank || !primed ||
           (slot == SLOT_TENS && BLANK_LEADING != 0 && shadow_tens == 4'd0);
    seg_next = dark ? '0 : pattern;
    an_next  = dark ? '0 : ((slot == SLOT_TENS) ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      slot        <= SLOT_ONES;
      shadow_tens <= '0;
      shadow_ones <= '0;
      primed      <= 1'b0;
      frame_start <= 1'b0;
      seg         <= {7{SEG_INV}};
      dp          <= SEG_INV;
      an          <= {2{AN_INV}};
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        slot <= (slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
      if (capture) begin
        shadow_tens <= digit_1;
        shadow_ones <= digit_2;
        primed      <= 1'b1;
      end
      frame_start <= capture;
      seg         <= seg_next ^ {7{SEG_INV}};
      dp          <= SEG_INV;
      an          <= an_next ^ {2{AN_INV}};
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: scoreboard of per-cycle expected outputs plus directed slot checks.
// Two instances differ only in leading-zero blanking.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic       blank;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [1:0] an_a, an_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(
    .REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .reset(reset), .digit_1(digit_1), .digit_2(digit_2), .blank(blank),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a)
  );

  bcd_display_scan #(
    .REFRESH_DIV(4), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .digit_1(digit_1), .digit_2(digit_2), .blank(blank),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  typedef struct packed {
    logic [6:0] seg_a;
    logic [1:0] an_a;
    logic [6:0] seg_b;
    logic [1:0] an_b;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  // Reference model: phase counter and slot flag, outputs derived as seen on the board.
  int         m_phase = 0;
  logic       m_tens  = 1'b0;
  logic [3:0] m_t = '0, m_o = '0;
  logic       m_primed = 1'b0;

  always @(posedge clk) begin : model
    exp_t       e;
    logic [3:0] d;
    logic       lit, lit_a, wrap;
    if (reset) begin
      e.seg_a = 7'h7F; e.an_a = 2'b11; e.seg_b = 7'h7F; e.an_b = 2'b11;
      e.dp = 1'b1; e.fs = 1'b0;
      m_phase = 0; m_tens = 1'b0; m_t = '0; m_o = '0; m_primed = 1'b0;
    end else begin
      d     = m_tens ? m_t : m_o;
      lit   = m_primed && !blank;
      lit_a = lit && !(m_tens && m_t == 4'd0);
      e.seg_b = lit   ? ~seg_of(d) : 7'h7F;
      e.an_b  = lit   ? (m_tens ? 2'b01 : 2'b10) : 2'b11;
      e.seg_a = lit_a ? ~seg_of(d) : 7'h7F;
      e.an_a  = lit_a ? (m_tens ? 2'b01 : 2'b10) : 2'b11;
      e.dp    = 1'b1;
      wrap    = (m_phase == 3);
      e.fs    = !m_primed || (wrap && m_tens);
      if (e.fs) begin
        m_t = digit_1; m_o = digit_2; m_primed = 1'b1;
      end
      if (wrap) begin
        m_phase = 0; m_tens = !m_tens;
      end else begin
        m_phase++;
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("sb_seg_a", seg_a, e.seg_a);
      check_val("sb_an_a",  an_a,  e.an_a);
      check_val("sb_seg_b", seg_b, e.seg_b);
      check_val("sb_an_b",  an_b,  e.an_b);
      check_val("sb_dp",    {dp_a, dp_b}, {e.dp, e.dp});
      check_val("sb_fs",    {fs_a, fs_b}, {e.fs, e.fs});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_seg", seg_a, 7'h7F);
    check_val("rst_an",  an_a,  2'b11);
    check_val("rst_fs",  fs_a,  1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; blank = 1'b0; digit_1 = 4'd4; digit_2 = 4'd2;
    step(2);

    // 42: dark first cycle, then ones, then tens after the first tick
    do_reset();
    step(1);
    check_val("t1_c1_an",  an_a,  2'b11);
    check_val("t1_c1_seg", seg_a, 7'h7F);
    check_val("t1_c1_dp",  dp_a,  1'b1);
    check_val("t1_c1_fs",  fs_a,  1'b1);
    step(1);
    check_val("t1_c2_an",  an_a,  2'b10);
    check_val("t1_c2_seg", seg_a, 7'h24);
    check_val("t1_c2_fs",  fs_a,  1'b0);
    step(3);
    check_val("t1_tens_an",  an_a,  2'b01);
    check_val("t1_tens_seg", seg_a, 7'h19);
    step(3);
    check_val("t1_cap_fs", fs_a, 1'b1);
    check_val("t1_cap_an", an_a, 2'b01);
    step(1);
    check_val("t1_ones2_an",  an_a,  2'b10);
    check_val("t1_ones2_seg", seg_a, 7'h24);

    // 07: leading-zero blanking on one instance only
    digit_1 = 4'd0; digit_2 = 4'd7;
    do_reset();
    step(2);
    check_val("t2_ones_an",  an_a,  2'b10);
    check_val("t2_ones_seg", seg_a, 7'h78);
    step(3);
    check_val("t2_tens_an",    an_a,  2'b11);
    check_val("t2_tens_seg",   seg_a, 7'h7F);
    check_val("t2_nb_tens_an", an_b,  2'b01);
    check_val("t2_nb_tens_seg", seg_b, 7'h40);

    // 53 -> 58 mid tens slot: change shows only after the frame capture
    digit_1 = 4'd5; digit_2 = 4'd3;
    do_reset();
    step(4);
    check_val("t3_ones3_seg", seg_a, 7'h30);
    step(1);
    check_val("t3_tens_seg", seg_a, 7'h12);
    digit_2 = 4'd8;
    step(2);
    check_val("t3_tens_an", an_a, 2'b01);
    check_val("t3_nofs",    fs_a, 1'b0);
    step(1);
    check_val("t3_fs", fs_a, 1'b1);
    step(1);
    check_val("t3_ones8_an",  an_a,  2'b10);
    check_val("t3_ones8_seg", seg_a, 7'h00);

    // invalid codes render as a dash, never blanked
    digit_1 = 4'd12; digit_2 = 4'd15;
    do_reset();
    step(2);
    check_val("t4_ones_dash", seg_a, 7'h3F);
    check_val("t4_ones_an",   an_a,  2'b10);
    step(3);
    check_val("t4_tens_dash", seg_a, 7'h3F);
    check_val("t4_tens_an",   an_a,  2'b01);

    // blank for 5 cycles mid ones slot; scan phase must be undisturbed
    digit_1 = 4'd4; digit_2 = 4'd2;
    do_reset();
    step(3);
    blank = 1'b1;
    step(1);
    check_val("t5_blank_an",  an_a,  2'b11);
    check_val("t5_blank_seg", seg_a, 7'h7F);
    step(4);
    check_val("t5_blank_end_an", an_a, 2'b11);
    blank = 1'b0;
    step(1);
    check_val("t5_ones_an",  an_a,  2'b10);
    check_val("t5_ones_seg", seg_a, 7'h24);
    step(4);
    check_val("t5_tens_an",  an_a,  2'b01);
    check_val("t5_tens_seg", seg_a, 7'h19);

    // reset during the tens slot restarts with ones
    do_reset();
    step(6);
    check_val("t6_in_tens", an_a, 2'b01);
    reset = 1'b1;
    step(1);
    check_val("t6_rst_an",  an_a,  2'b11);
    check_val("t6_rst_seg", seg_a, 7'h7F);
    check_val("t6_rst_dp",  dp_a,  1'b1);
    reset = 1'b0;
    step(2);
    check_val("t6_ones_an", an_a, 2'b10);

    // random inputs: never two anodes on at once
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_val("rnd_an_one_hot", {31'd0, an_a != 2'b00}, 32'd1);
      check_val("rnd_nb_one_hot", {31'd0, an_b != 2'b00}, 32'd1);
      digit_1 = 4'($urandom_range(0, 15));
      digit_2 = 4'($urandom_range(0, 15));
      blank   = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    blank = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
